mem_wb_reg: RTL and testbench

//  MEM/WB pipeline register of the 5-stage MIPS core. Captures the MEM-stage results
//  and presents the four candidates for each writeback 4:1 mux, destination (5-bit) and

---
 rtl/mem_wb_reg.sv | 146 ++++++++++++++
 tb/tb_mem_wb_reg.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: captures MEM results, formats load data, computes PC+8 link.
// Optional retired-instruction counter is built only when RETIRE_CNT_EN is defined.
module mem_wb_reg #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          stall_i,
   input  logic          flush_i,
   input  logic          mem_valid_i,
   input  logic          mem_rf_we_i,
   input  logic [AW-1:0] mem_rt_i,
   input  logic [AW-1:0] mem_rd_i,
   input  logic [1:0]    mem_waddr_sel_i,
   input  logic [1:0]    mem_wdata_sel_i,
   input  logic [DW-1:0] mem_alu_i,
   input  logic [DW-1:0] mem_rdata_i,
   input  logic [DW-1:0] mem_pc_i,
   input  logic [DW-1:0] mem_hilo_i,
   input  logic [2:0]    mem_ld_type_i,
   output logic          wb_valid_o,
   output logic          wb_rf_we_o,
   output logic [AW-1:0] wb_dest0_o,
   output logic [AW-1:0] wb_dest1_o,
   output logic [AW-1:0] wb_dest2_o,
   output logic [AW-1:0] wb_dest3_o,
   output logic [1:0]    wb_waddr_sel_o,
   output logic [DW-1:0] wb_data0_o,
   output logic [DW-1:0] wb_data1_o,
   output logic [DW-1:0] wb_data2_o,
   output logic [DW-1:0] wb_data3_o,
   output logic [1:0]    wb_wdata_sel_o,
   output logic [31:0]   wb_retire_cnt_o
);

   logic          r_valid;
   logic          r_rf_we;
   logic [AW-1:0] r_rt;
   logic [AW-1:0] r_rd;
   logic [1:0]    r_waddr_sel;
   logic [1:0]    r_wdata_sel;
   logic [DW-1:0] r_alu;
   logic [DW-1:0] r_load;
   logic [DW-1:0] r_link;
   logic [DW-1:0] r_hilo;

   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [DW-1:0] w_load;
   logic [DW-1:0] w_link;
   logic          w_capture;

   // Byte lane from the effective-address offset; halfword ignores a[0]
   always_comb begin
      w_byte = mem_rdata_i[7:0];
      case (mem_alu_i[1:0])
         2'd0:    w_byte = mem_rdata_i[7:0];
         2'd1:    w_byte = mem_rdata_i[15:8];
         2'd2:    w_byte = mem_rdata_i[23:16];
         default: w_byte = mem_rdata_i[31:24];
      endcase
      w_half = mem_alu_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
   end

   always_comb begin
      w_load = mem_rdata_i;
      case (mem_ld_type_i)
         3'b001:  w_load = {{(DW-8){w_byte[7]}}, w_byte};
         3'b010:  w_load = {{(DW-8){1'b0}}, w_byte};
         3'b011:  w_load = {{(DW-16){w_half[15]}}, w_half};
         3'b100:  w_load = {{(DW-16){1'b0}}, w_half};
         default: w_load = mem_rdata_i;
      endcase
   end

   assign w_link    = mem_pc_i + DW'(8);
   assign w_capture = !flush_i && !stall_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid     <= 1'b0;
         r_rf_we     <= 1'b0;
         r_rt        <= '0;
         r_rd        <= '0;
         r_waddr_sel <= '0;
         r_wdata_sel <= '0;
         r_alu       <= '0;
         r_load      <= '0;
         r_link      <= '0;
         r_hilo      <= '0;
      end else if (flush_i) begin
         r_valid     <= 1'b0;
         r_rf_we     <= 1'b0;
         r_rt        <= '0;
         r_rd        <= '0;
         r_waddr_sel <= '0;
         r_wdata_sel <= '0;
         r_alu       <= '0;
         r_load      <= '0;
         r_link      <= '0;
         r_hilo      <= '0;
      end else if (!stall_i) begin
         r_valid     <= mem_valid_i;
         r_rf_we     <= mem_rf_we_i & mem_valid_i;
         r_rt        <= mem_rt_i;
         r_rd        <= mem_rd_i;
         r_waddr_sel <= mem_waddr_sel_i;
         r_wdata_sel <= mem_wdata_sel_i;
         r_alu       <= mem_alu_i;
         r_load      <= w_load;
         r_link      <= w_link;
         r_hilo      <= mem_hilo_i;
      end
   end

`ifdef RETIRE_CNT_EN
   logic [31:0] r_retire_cnt;

   // Flush deliberately leaves the count alone; only reset clears it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_retire_cnt <= '0;
      else if (w_capture && mem_valid_i)
         r_retire_cnt <= r_retire_cnt + 32'd1;
   end

   assign wb_retire_cnt_o = r_retire_cnt;
`else
   assign wb_retire_cnt_o = 32'd0;
`endif

   assign wb_valid_o     = r_valid;
   assign wb_rf_we_o     = r_rf_we;
   assign wb_dest0_o     = r_rt;
   assign wb_dest1_o     = r_rd;
   assign wb_dest2_o     = AW'(31);
   assign wb_dest3_o     = '0;
   assign wb_waddr_sel_o = r_waddr_sel;
   assign wb_data0_o     = r_alu;
   assign wb_data1_o     = r_load;
   assign wb_data2_o     = r_link;
   assign wb_data3_o     = r_hilo;
   assign wb_wdata_sel_o = r_wdata_sel;

endmodule

// File: tb/tb_mem_wb_reg.sv
// Directed bench for mem_wb_reg: vector table plus reset, stall and retire-count sequences.
module tb_mem_wb_reg;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_i, flush_i, mem_valid_i, mem_rf_we_i;
   logic [4:0]  mem_rt_i, mem_rd_i;
   logic [1:0]  mem_waddr_sel_i, mem_wdata_sel_i;
   logic [31:0] mem_alu_i, mem_rdata_i, mem_pc_i, mem_hilo_i;
   logic [2:0]  mem_ld_type_i;
   logic        wb_valid_o, wb_rf_we_o;
   logic [4:0]  wb_dest0_o, wb_dest1_o, wb_dest2_o, wb_dest3_o;
   logic [1:0]  wb_waddr_sel_o, wb_wdata_sel_o;
   logic [31:0] wb_data0_o, wb_data1_o, wb_data2_o, wb_data3_o, wb_retire_cnt_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_wb_reg dut (
      .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
      .mem_valid_i(mem_valid_i), .mem_rf_we_i(mem_rf_we_i),
      .mem_rt_i(mem_rt_i), .mem_rd_i(mem_rd_i),
      .mem_waddr_sel_i(mem_waddr_sel_i), .mem_wdata_sel_i(mem_wdata_sel_i),
      .mem_alu_i(mem_alu_i), .mem_rdata_i(mem_rdata_i), .mem_pc_i(mem_pc_i),
      .mem_hilo_i(mem_hilo_i), .mem_ld_type_i(mem_ld_type_i),
      .wb_valid_o(wb_valid_o), .wb_rf_we_o(wb_rf_we_o),
      .wb_dest0_o(wb_dest0_o), .wb_dest1_o(wb_dest1_o),
      .wb_dest2_o(wb_dest2_o), .wb_dest3_o(wb_dest3_o),
      .wb_waddr_sel_o(wb_waddr_sel_o),
      .wb_data0_o(wb_data0_o), .wb_data1_o(wb_data1_o),
      .wb_data2_o(wb_data2_o), .wb_data3_o(wb_data3_o),
      .wb_wdata_sel_o(wb_wdata_sel_o), .wb_retire_cnt_o(wb_retire_cnt_o)
   );

   typedef struct {
      logic        stall, flush, valid, we;
      logic [4:0]  rt, rd;
      logic [1:0]  wsel, dsel;
      logic [31:0] alu, rdata, pc, hilo;
      logic [2:0]  ldt;
      logic        e_valid, e_we;
      logic [4:0]  e_d0, e_d1;
      logic [1:0]  e_wsel, e_dsel;
      logic [31:0] e_alu, e_ld, e_link, e_hilo;
   } vec_t;

   localparam logic [31:0] R = 32'h80FF7F01;
   localparam int NV = 15;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      stall_i = v.stall; flush_i = v.flush; mem_valid_i = v.valid; mem_rf_we_i = v.we;
      mem_rt_i = v.rt; mem_rd_i = v.rd; mem_waddr_sel_i = v.wsel; mem_wdata_sel_i = v.dsel;
      mem_alu_i = v.alu; mem_rdata_i = v.rdata; mem_pc_i = v.pc; mem_hilo_i = v.hilo;
      mem_ld_type_i = v.ldt;
   endtask

   task automatic chk_outs(input string tag, input vec_t v);
      chk({tag, ".valid"}, 32'(wb_valid_o),     32'(v.e_valid));
      chk({tag, ".we"},    32'(wb_rf_we_o),     32'(v.e_we));
      chk({tag, ".dest0"}, 32'(wb_dest0_o),     32'(v.e_d0));
      chk({tag, ".dest1"}, 32'(wb_dest1_o),     32'(v.e_d1));
      chk({tag, ".dest2"}, 32'(wb_dest2_o),     32'd31);
      chk({tag, ".dest3"}, 32'(wb_dest3_o),     32'd0);
      chk({tag, ".wsel"},  32'(wb_waddr_sel_o), 32'(v.e_wsel));
      chk({tag, ".dsel"},  32'(wb_wdata_sel_o), 32'(v.e_dsel));
      chk({tag, ".data0"}, wb_data0_o, v.e_alu);
      chk({tag, ".data1"}, wb_data1_o, v.e_ld);
      chk({tag, ".data2"}, wb_data2_o, v.e_link);
      chk({tag, ".data3"}, wb_data3_o, v.e_hilo);
   endtask

   task automatic set_cap(input logic valid, input logic stall, input logic flush);
      stall_i = stall; flush_i = flush; mem_valid_i = valid; mem_rf_we_i = 1'b1;
      mem_alu_i = 32'h0000_00AA; mem_pc_i = 32'h0000_1000;
      @(posedge clk); #1;
      @(negedge clk);
   endtask

   vec_t zero_v, hold_v;

   initial begin
      // stall flush valid we | rt rd | wsel dsel | alu rdata pc hilo ldt || expected
      vecs[0]  = '{0,0,1,1, 5'd3, 5'd8, 2'b01,2'b00, 32'h1234, 32'h0, 32'h100, 32'h55, 3'd0,
                   1,1, 5'd3, 5'd8, 2'b01,2'b00, 32'h1234, 32'h0, 32'h108, 32'h55};
      vecs[1]  = '{0,0,1,1, 5'd9, 5'd0, 2'b00,2'b01, 32'h1003, R, 32'h200, 32'h0, 3'd1,
                   1,1, 5'd9, 5'd0, 2'b00,2'b01, 32'h1003, 32'hFFFFFF80, 32'h208, 32'h0};
      vecs[2]  = '{0,0,1,1, 5'd10,5'd1, 2'b00,2'b01, 32'h2001, R, 32'h204, 32'h0, 3'd2,
                   1,1, 5'd10,5'd1, 2'b00,2'b01, 32'h2001, 32'h0000007F, 32'h20C, 32'h0};
      vecs[3]  = '{0,0,1,1, 5'd11,5'd2, 2'b00,2'b01, 32'h2002, R, 32'h208, 32'h0, 3'd3,
                   1,1, 5'd11,5'd2, 2'b00,2'b01, 32'h2002, 32'hFFFF80FF, 32'h210, 32'h0};
      vecs[4]  = '{0,0,1,0, 5'd12,5'd3, 2'b00,2'b01, 32'h2000, R, 32'h20C, 32'h0, 3'd4,
                   1,0, 5'd12,5'd3, 2'b00,2'b01, 32'h2000, 32'h00007F01, 32'h214, 32'h0};
      vecs[5]  = '{0,0,1,1, 5'd13,5'd4, 2'b00,2'b01, 32'h2004, R, 32'h210, 32'h0, 3'd0,
                   1,1, 5'd13,5'd4, 2'b00,2'b01, 32'h2004, R, 32'h218, 32'h0};
      vecs[6]  = '{0,0,1,1, 5'd14,5'd5, 2'b00,2'b01, 32'h2001, R, 32'h214, 32'h0, 3'd7,
                   1,1, 5'd14,5'd5, 2'b00,2'b01, 32'h2001, R, 32'h21C, 32'h0};
      vecs[7]  = '{0,0,1,1, 5'd15,5'd6, 2'b00,2'b01, 32'h2003, R, 32'h218, 32'h0, 3'd4,
                   1,1, 5'd15,5'd6, 2'b00,2'b01, 32'h2003, 32'h000080FF, 32'h220, 32'h0};
      vecs[8]  = '{0,0,1,1, 5'd16,5'd7, 2'b00,2'b01, 32'h3000, 32'hF0, 32'h21C, 32'h0, 3'd1,
                   1,1, 5'd16,5'd7, 2'b00,2'b01, 32'h3000, 32'hFFFFFFF0, 32'h224, 32'h0};
      vecs[9]  = '{0,0,1,1, 5'd0, 5'd0, 2'b10,2'b10, 32'h0, 32'h0, 32'hFFFFFFFC, 32'hABCD, 3'd0,
                   1,1, 5'd0, 5'd0, 2'b10,2'b10, 32'h0, 32'h0, 32'h4, 32'hABCD};
      vecs[10] = '{0,0,1,1, 5'd1, 5'd2, 2'b11,2'b11, 32'h0, 32'h0, 32'hFFFFFFF8, 32'h0, 3'd0,
                   1,1, 5'd1, 5'd2, 2'b11,2'b11, 32'h0, 32'h0, 32'h0, 32'h0};
      vecs[11] = '{0,0,0,1, 5'd4, 5'd5, 2'b01,2'b00, 32'h77, 32'h0, 32'h300, 32'h0, 3'd0,
                   0,0, 5'd4, 5'd5, 2'b01,2'b00, 32'h77, 32'h0, 32'h308, 32'h0};
      vecs[12] = '{1,0,1,1, 5'd31,5'd31,2'b10,2'b11, 32'hFFFF, 32'hFFFF, 32'h400, 32'h1, 3'd0,
                   0,0, 5'd4, 5'd5, 2'b01,2'b00, 32'h77, 32'h0, 32'h308, 32'h0};
      vecs[13] = '{1,1,1,1, 5'd31,5'd31,2'b10,2'b11, 32'hFFFF, 32'hFFFF, 32'h400, 32'h1, 3'd0,
                   0,0, 5'd0, 5'd0, 2'b00,2'b00, 32'h0, 32'h0, 32'h0, 32'h0};
      vecs[14] = '{0,0,1,1, 5'd2, 5'd3, 2'b01,2'b11, 32'h5, 32'h6, 32'h10, 32'h9, 3'd0,
                   1,1, 5'd2, 5'd3, 2'b01,2'b11, 32'h5, 32'h6, 32'h18, 32'h9};
      zero_v = vecs[13];

      // Reset at time zero, no clock edge needed
      rst_n = 1'b0;
      drive(vecs[0]);
      #2;
      chk_outs("reset0", zero_v);
      chk("reset0.cnt", wb_retire_cnt_o, 32'd0);

      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i]);
         @(posedge clk); #1;
         chk_outs($sformatf("vec%0d", i), vecs[i]);
         @(negedge clk);
      end

      // Stall three cycles with changing inputs: outputs frozen at vec 0's capture
      drive(vecs[0]);
      @(posedge clk); #1;
      @(negedge clk);
      hold_v = vecs[0];
      for (int i = 0; i < 3; i++) begin
         drive(vecs[i + 1]);
         stall_i = 1'b1;
         @(posedge clk); #1;
         chk_outs($sformatf("stall%0d", i), hold_v);
         @(negedge clk);
      end

      // Async reset mid-cycle while stalled with valid data held
      drive(vecs[0]);
      stall_i = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk_outs("reset_mid", zero_v);
      @(posedge clk); #1;
      chk_outs("reset_held", zero_v);

      // Release is not visible until the next rising edge
      @(negedge clk);
      stall_i = 1'b0;
      #2;
      rst_n = 1'b1;
      #1;
      chk("rel.valid_before_edge", 32'(wb_valid_o), 32'd0);
      @(posedge clk); #1;
      chk_outs("rel.after_edge", vecs[0]);
      @(negedge clk);

      // Retire counter: fresh reset, then 5 valid captures among 2 stalls and 1 flush
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      set_cap(1, 0, 0);
      set_cap(1, 0, 0);
      set_cap(1, 1, 0);
      set_cap(1, 0, 0);
      set_cap(1, 1, 0);
      set_cap(1, 0, 0);
      set_cap(1, 0, 1);
      set_cap(0, 0, 0);
      set_cap(1, 0, 0);
`ifdef RETIRE_CNT_EN
      chk("cnt.five", wb_retire_cnt_o, 32'd5);
      dut.r_retire_cnt = 32'hFFFFFFFF;
      set_cap(1, 0, 0);
      chk("cnt.wrap", wb_retire_cnt_o, 32'd0);
`else
      chk("cnt.disabled", wb_retire_cnt_o, 32'd0);
      set_cap(1, 0, 0);
      chk("cnt.disabled2", wb_retire_cnt_o, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
